// File: rtl/pipe_pkg.sv
// Shared types for the writeback tracker: register width, stage slot, FSM states.
package pipe_pkg;

    localparam int unsigned REG_BITS = 3;
    localparam int unsigned NUM_REGS = 1 << REG_BITS;

    // One pipeline stage worth of destination tracking
    typedef struct packed {
        logic [REG_BITS-1:0] dest;
        logic                regwrite;
        logic                load;
    } slot_t;

    localparam slot_t BUBBLE = '{dest: '0, regwrite: 1'b0, load: 1'b0};

    typedef enum logic [0:0] {
        IDLE,
        RESOLVE
    } state_t;

endpackage

// File: rtl/stage_slot_reg.sv
// Single resettable pipeline slot; bubble forces an empty slot on the next edge.
module stage_slot_reg
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    // Capture incoming slot, or an empty one when bubbled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/writeback_tracker.sv
// Tracks destination tags through EX/MEM/WB, exposes them to the hazard unit,
// keeps a pending-write scoreboard and holds fetch while a branch resolves.
module writeback_tracker
    import pipe_pkg::*;
#(
    parameter int unsigned BRANCH_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                IssueValid,
    input  logic [REG_BITS-1:0] IssueRd,
    input  logic                IssueRegWrite,
    input  logic                IssueLoad,
    input  logic                BranchD,
    input  logic                ForSignalD,
    output logic [REG_BITS-1:0] WB1,
    output logic                RegWriteM,
    output logic                LoadM,
    output logic [REG_BITS-1:0] WB2,
    output logic                RegWriteW,
    output logic [REG_BITS-1:0] WB3,
    output logic [NUM_REGS-1:0] Pending,
    output logic                FetchHold
);

    localparam int unsigned CNT_BITS = 3;

    slot_t issue_slot;
    slot_t ex_q, mem_q, wb_q, ret_q;
    logic  ex_bubble;

    state_t             state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic               branch_accept;

    // Build the decode slot; R0 writes never count as register writes
    always_comb begin
        issue_slot          = BUBBLE;
        issue_slot.dest     = IssueRd;
        issue_slot.regwrite = IssueRegWrite && (IssueRd != '0);
        issue_slot.load     = IssueLoad;
    end

    // Flush and Stall both collapse to a single bubble
    assign ex_bubble = Flush || Stall || !IssueValid;

    stage_slot_reg u_ex (
        .clk    (clk),
        .reset  (reset),
        .bubble (ex_bubble),
        .d      (issue_slot),
        .q      (ex_q)
    );

    // Downstream stages always advance, independent of Stall
    stage_slot_reg u_mem (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    stage_slot_reg u_wb (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    stage_slot_reg u_ret (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (wb_q),
        .q      (ret_q)
    );

    assign WB1       = mem_q.dest;
    assign RegWriteM = mem_q.regwrite;
    assign LoadM     = mem_q.load;
    assign WB2       = wb_q.dest;
    assign RegWriteW = wb_q.regwrite;
    assign WB3       = ret_q.dest;

    // Only the retired destination is observable
    logic unused_ret;
    assign unused_ret = ret_q.regwrite ^ ret_q.load;

    // Scoreboard: one bit per register with a write still in flight
    always_comb begin
        Pending = '0;
        if (ex_q.regwrite)  Pending[ex_q.dest]  = 1'b1;
        if (mem_q.regwrite) Pending[mem_q.dest] = 1'b1;
        if (wb_q.regwrite)  Pending[wb_q.dest]  = 1'b1;
        Pending[0] = 1'b0;
    end

    assign branch_accept = (BranchD || ForSignalD) && IssueValid && !Stall;

    // Branch FSM next state; branches seen while resolving are ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (branch_accept) begin
                    state_d = RESOLVE;
                    cnt_d   = CNT_BITS'(BRANCH_LAT - 1);
                end
            end
            RESOLVE: begin
                if (Flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Branch FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign FetchHold = (state_q == RESOLVE);

endmodule

// File: doc/writeback_tracker.md
Name: writeback_tracker

Overview: Tracks the destination-register tags of in-flight instructions through the EX, MEM and WB stages. It generates the WB1/WB2/WB3, RegWriteM, RegWriteW and LoadM signals that the hazard detection logic consumes, and it acts on the Stall that logic returns: bubble insertion, flush, and a multi-cycle branch-resolution hold. It also keeps a pending-write scoreboard for the 8-entry register file, in which R0 is hardwired to zero.

Parameters:
REG_BITS, 3, width of a register index
BRANCH_LAT, 2, cycles from BranchD/ForSignalD acceptance until the branch resolves in EX (range 1..7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Stall  in  1  stall from the hazard unit; hold decode, inject a bubble into EX
Flush  in  1  taken-branch kill of the instruction entering EX
IssueValid  in  1  decode presents a valid instruction
IssueRd  in  REG_BITS  destination register of the decode instruction
IssueRegWrite  in  1  decode instruction writes IssueRd
IssueLoad  in  1  decode instruction is a load
BranchD  in  1  decode instruction is a branch
ForSignalD  in  1  decode instruction is a loop/for-branch
WB1  out  REG_BITS  MEM-stage destination
RegWriteM  out  1  MEM-stage write enable
LoadM  out  1  MEM-stage load flag
WB2  out  REG_BITS  WB-stage destination
RegWriteW  out  1  WB-stage write enable
WB3  out  REG_BITS  destination retired last cycle (register-file write-through window)
Pending  out  8  bit r set while any of EX/MEM/WB holds a write to r
FetchHold  out  1  fetch must not advance (branch resolution in progress)

Behaviour:
- One clock; reset is asynchronous and active-high. On reset, all stage slots are cleared (dest=0, regwrite=0, load=0). Resulting values: WB1=WB2=WB3=0, RegWriteM=RegWriteW=LoadM=0, Pending=0, FetchHold=0, FSM=IDLE, counter=0.
- Stage slots are EX, MEM and WB, each holding {dest, regwrite, load}. Every cycle they shift EX->MEM->WB->retired. The retired slot contributes only WB3. Downstream stages always advance; Stall never freezes MEM/WB.
- EX load value, evaluated in priority order:
  - reset
  - Flush or Stall: bubble {0,0,0}
  - IssueValid: {IssueRd, IssueRegWrite && IssueRd!=0, IssueLoad}
  - otherwise: bubble
- A write to R0 never sets regwrite. Its load flag is still propagated, so LoadM can be 1 with RegWriteM=0.
- Outputs are registered. An instruction accepted in cycle N appears on WB1 in N+2, on WB2 in N+3 and on WB3 in N+4.
- Pending is combinational: the OR of one-hot(dest) over slots with regwrite=1. Bit 0 is always 0.
- Branch FSM, states IDLE and RESOLVE:
  - IDLE -> RESOLVE when (BranchD || ForSignalD) && IssueValid && !Stall. The counter loads BRANCH_LAT-1.
  - In RESOLVE, FetchHold=1 and the counter decrements each cycle. At 0 the FSM returns to IDLE, and FetchHold drops the following cycle.
  - A branch presented during a Stall is not accepted. It is re-presented once the Stall clears.
  - Flush in RESOLVE terminates resolution: next state is IDLE.
  - A branch in decode while in RESOLVE is ignored, because fetch is held.
- Simultaneous Stall and Flush: a single bubble results and no double action occurs.
- Reset mid-RESOLVE: immediate return to IDLE with FetchHold=0.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_BITS
  - the stage-slot struct {dest, regwrite, load}
  - the BUBBLE constant
  - the FSM state enum {IDLE, RESOLVE}
- One natural sub-module, stage_slot_reg: a single resettable slot register with a bubble-select input, instantiated three times plus once for the retired slot.
- The scoreboard OR and the FSM stay in the top level.

Test Plan:
- Reset/propagation: reset asserted mid-run clears all outputs. Issue rd=3, regwrite=1 at N -> WB1=3 with RegWriteM=1 at N+2, WB2=3 with RegWriteW=1 at N+3, WB3=3 at N+4. Pending[3]=1 from N+1 through N+3, 0 at N+4.
- Load-use bubble: issue load rd=5 at N, with Stall=1 at N+1 while another rd=6 is presented -> LoadM=1 and WB1=5 at N+2; RegWriteM=0 at N+3 (bubble); the rd=6 entry is absent until re-issued.
- R0 write: issue rd=0, regwrite=1, load=1 -> RegWriteM=0, LoadM=1, Pending stays 0.
- Branch resolve with BRANCH_LAT=2: BranchD with IssueValid at N -> FetchHold=1 at N+1 and N+2, 0 at N+3. ForSignalD behaves identically. A branch at N while Stall=1 -> no hold until re-presented.
- Flush: Flush at N+1 during RESOLVE -> FetchHold=0 at N+2. The instruction issued at N+1 never reaches WB1, and Pending for it stays 0.
- Simultaneous Stall+Flush with valid issue rd=2 -> a single bubble; WB1 != 2 two cycles later and Pending[2]=0.
